// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: hands the vertical blanking interval to game-object
// update engines one at a time over a req/ack handshake, once per frame.
//
// Ports:
//   vga_clk      in   pixel clock shared with the VGA timing block
//   clr          in   synchronous active-high reset
//   rdn          in   registered read strobe (0 = visible pixel)
//   row_addr     in   registered row address [8:0]
//   client_en    in   per-client enable, sampled at frame end
//   upd_ack      in   per-client done pulse/level
//   upd_req      out  one-hot (or zero) update request
//   frame_tick   out  one-cycle pulse at each accepted frame end
//   busy         out  high while a client is pending in this frame
//   overrun      out  sticky: frame end seen while busy
//   late         out  sticky: visible region started while busy
//   err_timeout  out  sticky per client: request timed out
//   frame_cnt    out  frame counter [15:0]
//
// Optional feature: define FRAME_CNT_EN to build the frame counter;
// otherwise frame_cnt is tied to zero.

module vga_frame_scheduler #(
    parameter int N_CLIENTS = 3,
    parameter int TIMEOUT   = 1023,
    parameter int LAST_ROW  = 479
) (
    input  logic                 vga_clk,
    input  logic                 clr,
    input  logic                 rdn,
    input  logic [8:0]           row_addr,
    input  logic [N_CLIENTS-1:0] client_en,
    input  logic [N_CLIENTS-1:0] upd_ack,
    output logic [N_CLIENTS-1:0] upd_req,
    output logic                 frame_tick,
    output logic                 busy,
    output logic                 overrun,
    output logic                 late,
    output logic [N_CLIENTS-1:0] err_timeout,
    output logic [15:0]          frame_cnt
);

    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [N_CLIENTS-1:0] ONE = N_CLIENTS'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        NEXT
    } state_t;

    state_t               state_q;
    logic                 rdn_q;
    logic [8:0]           row_q;
    logic [N_CLIENTS-1:0] mask_q;
    logic [IW-1:0]        idx_q;
    logic [TW-1:0]        timer_q;
    logic [N_CLIENTS-1:0] upd_req_q;
    logic                 frame_tick_q;
    logic                 busy_q;
    logic                 overrun_q;
    logic                 late_q;
    logic [N_CLIENTS-1:0] err_q;

    logic          fe;
    logic          rdn_fall;
    logic          ack_hit;
    logic          tmo;
    logic          first_vld;
    logic [IW-1:0] first_idx;
    logic          nxt_vld;
    logic [IW-1:0] nxt_idx;

    // Rising rdn right after the last visible row marks frame end.
    assign fe       = rdn & ~rdn_q & (row_q == 9'(LAST_ROW));
    assign rdn_fall = rdn_q & ~rdn;
    assign ack_hit  = upd_ack[idx_q];
    assign tmo      = (timer_q == TW'(TIMEOUT - 1));

    // Lowest enabled client at frame start; downward scan keeps the lowest.
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (client_en[i]) begin
                first_vld = 1'b1;
                first_idx = IW'(i);
            end
        end
    end

    // Next enabled client strictly above the one just served.
    always_comb begin
        nxt_vld = 1'b0;
        nxt_idx = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(idx_q))) begin
                nxt_vld = 1'b1;
                nxt_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (clr) begin
            state_q      <= IDLE;
            rdn_q        <= 1'b1;
            row_q        <= '0;
            mask_q       <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            upd_req_q    <= '0;
            frame_tick_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            late_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            rdn_q        <= rdn;
            row_q        <= row_addr;
            frame_tick_q <= 1'b0;

            // A frame end while busy is only flagged; the
            // running sequence is never restarted.
            if (fe && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            if (rdn_fall && (state_q != IDLE)) begin
                late_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (fe) begin
                        frame_tick_q <= 1'b1;
                        mask_q       <= client_en;
                        timer_q      <= '0;
                        if (first_vld) begin
                            idx_q     <= first_idx;
                            upd_req_q <= ONE << first_idx;
                            state_q   <= REQ;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    timer_q <= timer_q + 1'b1;
                    if (ack_hit || tmo) begin
                        if (!ack_hit) begin
                            err_q[idx_q] <= 1'b1;
                        end
                        upd_req_q <= '0;
                        state_q   <= NEXT;
                    end
                end
                NEXT: begin
                    timer_q <= '0;
                    if (nxt_vld) begin
                        idx_q     <= nxt_idx;
                        upd_req_q <= ONE << nxt_idx;
                        state_q   <= REQ;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    upd_req_q <= '0;
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Advances on the same edge that raises frame_tick.
    always_ff @(posedge vga_clk) begin
        if (clr) begin
            frame_cnt_q <= '0;
        end else if (fe && (state_q == IDLE)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0;
`endif

    assign upd_req     = upd_req_q;
    assign frame_tick  = frame_tick_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign late        = late_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler: table of per-frame client scenarios with a
// request scoreboard, plus hand sequences for overrun, late and reset.

module tb_vga_frame_scheduler;

    localparam int TMO = 8;

    logic        vga_clk = 1'b0;
    logic        clr;
    logic        rdn;
    logic [8:0]  row_addr;
    logic [2:0]  client_en;
    logic [2:0]  upd_ack;
    logic [2:0]  upd_req;
    logic        frame_tick;
    logic        busy;
    logic        overrun;
    logic        late;
    logic [2:0]  err_timeout;
    logic [15:0] frame_cnt;

    logic [2:0]  resp_ack;
    logic [2:0]  xack;
    logic [2:0]  noack;
    int          dly[3];
    int          cnt[3];

    assign upd_ack = resp_ack | xack;

    always #5 vga_clk = ~vga_clk;

    vga_frame_scheduler #(
        .N_CLIENTS(3),
        .TIMEOUT(TMO),
        .LAST_ROW(479)
    ) dut (
        .vga_clk(vga_clk),
        .clr(clr),
        .rdn(rdn),
        .row_addr(row_addr),
        .client_en(client_en),
        .upd_ack(upd_ack),
        .upd_req(upd_req),
        .frame_tick(frame_tick),
        .busy(busy),
        .overrun(overrun),
        .late(late),
        .err_timeout(err_timeout),
        .frame_cnt(frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected requests: value and cycles held high.
    typedef struct {
        logic [2:0] req;
        int         dur;
    } exp_t;

    exp_t sb[$];

    logic mon_en = 1'b0;

    // Request monitor.
    initial begin
        logic [2:0] prev_req;
        int cur_dur;
        int cur_exp;
        int gap;
        bit in_seq;
        exp_t e;
        prev_req = '0;
        cur_dur  = 0;
        cur_exp  = 0;
        gap      = 0;
        in_seq   = 0;
        forever begin
            @(negedge vga_clk);
            if (clr !== 1'b0 || !mon_en) begin
                prev_req = '0;
                in_seq   = 0;
                cur_dur  = 0;
                gap      = 0;
            end else begin
                if (frame_tick) in_seq = 0;
                if (upd_req != 0 && prev_req == 0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_req", 32'(upd_req), 0);
                    end else begin
                        e = sb.pop_front();
                        check("req_value", 32'(upd_req), 32'(e.req));
                        cur_exp = e.dur;
                    end
                    if (in_seq) check("req_gap", gap, 1);
                    cur_dur = 1;
                end else if (upd_req != 0) begin
                    cur_dur++;
                end else if (prev_req != 0) begin
                    check("req_dur", cur_dur, cur_exp);
                    in_seq = 1;
                    gap    = 1;
                end else begin
                    gap++;
                end
                prev_req = upd_req;
            end
        end
    end

    // Ack responder: acks client i on the dly[i]-th cycle of its request.
    initial begin
        resp_ack = '0;
        cnt = '{0, 0, 0};
        forever begin
            @(negedge vga_clk);
            for (int i = 0; i < 3; i++) begin
                if (upd_req[i] === 1'b1) begin
                    cnt[i]++;
                    resp_ack[i] = !noack[i] && (cnt[i] >= dly[i]);
                end else begin
                    cnt[i]      = 0;
                    resp_ack[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int exp_fc = 0;

    task automatic check_fc();
`ifdef FRAME_CNT_EN
        check("frame_cnt", 32'(frame_cnt), exp_fc);
`else
        check("frame_cnt", 32'(frame_cnt), 0);
`endif
    endtask

    // Ends at the negedge following the frame-end posedge.
    task automatic fire_fe();
        @(negedge vga_clk);
        rdn      = 1'b0;
        row_addr = 9'd479;
        @(negedge vga_clk);
        rdn      = 1'b1;
        row_addr = 9'd480;
        @(negedge vga_clk);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 100) begin
            @(negedge vga_clk);
            c++;
        end
        check("idle_in_time", 32'(c < 100), 1);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        clr    = 1'b1;
        xack   = '0;
        noack  = 3'b111;
        @(negedge vga_clk);
        @(negedge vga_clk);
        clr    = 1'b0;
        exp_fc = 0;
        sb.delete();
    endtask

    typedef struct {
        logic [2:0] en;
        int         d0, d1, d2;
        logic [2:0] noack;
        logic [2:0] xack;
        int         nexp;
        logic [2:0] r0, r1, r2;
        int         e0, e1, e2;
        logic [2:0] eerr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{en:3'b111, d0:5, d1:5, d2:5, noack:3'b000, xack:3'b000,
                   nexp:3, r0:3'b001, r1:3'b010, r2:3'b100,
                   e0:5, e1:5, e2:5, eerr:3'b000};
        tbl[1] = '{en:3'b101, d0:3, d1:9, d2:2, noack:3'b000, xack:3'b000,
                   nexp:2, r0:3'b001, r1:3'b100, r2:3'b000,
                   e0:3, e1:2, e2:0, eerr:3'b000};
        tbl[2] = '{en:3'b111, d0:2, d1:1, d2:4, noack:3'b010, xack:3'b000,
                   nexp:3, r0:3'b001, r1:3'b010, r2:3'b100,
                   e0:2, e1:TMO, e2:4, eerr:3'b010};
        tbl[3] = '{en:3'b001, d0:1, d1:1, d2:1, noack:3'b001, xack:3'b110,
                   nexp:1, r0:3'b001, r1:3'b000, r2:3'b000,
                   e0:TMO, e1:0, e2:0, eerr:3'b011};
        tbl[4] = '{en:3'b000, d0:1, d1:1, d2:1, noack:3'b000, xack:3'b000,
                   nexp:0, r0:3'b000, r1:3'b000, r2:3'b000,
                   e0:0, e1:0, e2:0, eerr:3'b011};
        tbl[5] = '{en:3'b011, d0:7, d1:1, d2:1, noack:3'b000, xack:3'b000,
                   nexp:2, r0:3'b001, r1:3'b010, r2:3'b000,
                   e0:7, e1:1, e2:0, eerr:3'b011};
        tbl[6] = '{en:3'b100, d0:1, d1:1, d2:1, noack:3'b000, xack:3'b000,
                   nexp:1, r0:3'b100, r1:3'b000, r2:3'b000,
                   e0:1, e1:0, e2:0, eerr:3'b011};

        clr       = 1'b1;
        rdn       = 1'b1;
        row_addr  = '0;
        client_en = '0;
        xack      = 3'b111;
        noack     = 3'b111;
        dly       = '{1, 1, 1};

        // Reset held for three edges with all acks high.
        repeat (3) @(negedge vga_clk);
        check("rst_upd_req", 32'(upd_req), 0);
        check("rst_frame_tick", 32'(frame_tick), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_late", 32'(late), 0);
        check("rst_err", 32'(err_timeout), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        clr   = 1'b0;
        xack  = '0;
        noack = '0;
        @(negedge vga_clk);
        mon_en = 1'b1;

        for (int v = 0; v < 7; v++) begin
            client_en = tbl[v].en;
            dly       = '{tbl[v].d0, tbl[v].d1, tbl[v].d2};
            noack     = tbl[v].noack;
            xack      = tbl[v].xack;
            if (tbl[v].nexp > 0) sb.push_back('{tbl[v].r0, tbl[v].e0});
            if (tbl[v].nexp > 1) sb.push_back('{tbl[v].r1, tbl[v].e1});
            if (tbl[v].nexp > 2) sb.push_back('{tbl[v].r2, tbl[v].e2});
            fire_fe();
            exp_fc++;
            check("tick", 32'(frame_tick), 1);
            check("busy_at_tick", 32'(busy), 32'(tbl[v].en != 0));
            check_fc();
            @(negedge vga_clk);
            check("tick_width", 32'(frame_tick), 0);
            wait_idle();
            repeat (2) @(negedge vga_clk);
            check("sb_drained", sb.size(), 0);
            check("err_timeout", 32'(err_timeout), 32'(tbl[v].eerr));
            check("no_overrun", 32'(overrun), 0);
            check("no_late", 32'(late), 0);
            xack = '0;
        end

        // Visible start and next frame end while client 0 still holds.
        do_reset();
        client_en = 3'b001;
        fire_fe();
        exp_fc++;
        check("ovr_tick", 32'(frame_tick), 1);
        rdn      = 1'b0;
        row_addr = 9'd0;
        @(negedge vga_clk);
        check("late_set", 32'(late), 1);
        check("ovr_not_yet", 32'(overrun), 0);
        row_addr = 9'd479;
        @(negedge vga_clk);
        rdn      = 1'b1;
        row_addr = 9'd480;
        @(negedge vga_clk);
        check("tick_suppressed", 32'(frame_tick), 0);
        check("overrun_set", 32'(overrun), 1);
        check("seq_continues", 32'(upd_req), 32'(3'b001));
        check_fc();
        wait_idle();
        check("ovr_err", 32'(err_timeout), 32'(3'b001));
        check("late_sticky", 32'(late), 1);

        // Frame end on the same edge as the final ack.
        do_reset();
        client_en = 3'b001;
        fire_fe();
        rdn      = 1'b0;
        row_addr = 9'd479;
        @(negedge vga_clk);
        rdn      = 1'b1;
        row_addr = 9'd480;
        xack     = 3'b001;
        @(negedge vga_clk);
        check("fe_ack_overrun", 32'(overrun), 1);
        check("fe_ack_no_tick", 32'(frame_tick), 0);
        check("fe_ack_req_drop", 32'(upd_req), 0);
        xack = '0;
        wait_idle();
        check("fe_ack_no_err", 32'(err_timeout), 0);

        // Reset in the middle of a request.
        do_reset();
        client_en = 3'b111;
        fire_fe();
        check("mid_req_active", 32'(upd_req), 32'(3'b001));
        @(negedge vga_clk);
        clr = 1'b1;
        @(negedge vga_clk);
        check("mid_clr_req", 32'(upd_req), 0);
        check("mid_clr_busy", 32'(busy), 0);
        exp_fc = 0;
        check_fc();
        clr = 1'b0;
        repeat (3) @(negedge vga_clk);
        check("mid_clr_stays", 32'(upd_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
